// File: rtl/ysyx_23060201_dmem_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060201_dmem_pkg
// Shared definitions for the data-memory responder: FSM state codes,
// access-size codes carried in mask[3:0], and the load sign-extend bit.
// No ports (package).
// ---------------------------------------------------------------------------
package ysyx_23060201_dmem_pkg;

    // Responder FSM: IDLE accepts, WAIT models latency, RESP holds the result
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmemState_e;

    localparam logic [3:0] SIZE_B   = 4'b0001;
    localparam logic [3:0] SIZE_H   = 4'b0011;
    localparam logic [3:0] SIZE_W   = 4'b1111;
    localparam int         SIGN_BIT = 4;

    // Only byte, halfword and word size codes are legal
    function automatic logic sizeValid(input logic [3:0] size);
        return (size == SIZE_B) || (size == SIZE_H) || (size == SIZE_W);
    endfunction

endpackage

// File: rtl/ysyx_23060201_dmem_align.sv
// ---------------------------------------------------------------------------
// ysyx_23060201_dmem_align
// Combinational byte-lane helper for the data-memory responder.
// Store side: turns size code + low address bits into a 4-bit lane strobe
// and lane-positioned write data. Load side: shifts the raw SRAM word down
// and keeps 8/16/32 bits with optional sign extension.
// Ports:
//   addrLo_i     in  2   byte offset within the word
//   mask_i       in  5   [3:0] size code, [4] load sign-extend
//   wdata_i      in  32  store data, LSB-aligned
//   rawWord_i    in  32  word read from SRAM
//   strobe_o     out 4   byte-lane write enables
//   laneData_o   out 32  store data shifted into its lanes
//   alignErr_o   out 1   illegal size code or misaligned access
//   loadData_o   out 32  extracted and extended load data
// ---------------------------------------------------------------------------
module ysyx_23060201_dmem_align
    import ysyx_23060201_dmem_pkg::*;
(
    input  logic [1:0]  addrLo_i,
    input  logic [4:0]  mask_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rawWord_i,
    output logic [3:0]  strobe_o,
    output logic [31:0] laneData_o,
    output logic        alignErr_o,
    output logic [31:0] loadData_o
);

    logic [3:0]  size;
    logic        signExt;
    logic [31:0] shifted;

    assign size    = mask_i[3:0];
    assign signExt = mask_i[SIGN_BIT];

    assign strobe_o   = size << addrLo_i;
    assign laneData_o = wdata_i << {addrLo_i, 3'b000};
    assign shifted    = rawWord_i >> {addrLo_i, 3'b000};

    // Halfwords need an even offset, words need offset zero
    always_comb begin
        alignErr_o = 1'b0;
        if (!sizeValid(size)) begin
            alignErr_o = 1'b1;
        end else if ((size == SIZE_H) && addrLo_i[0]) begin
            alignErr_o = 1'b1;
        end else if ((size == SIZE_W) && (addrLo_i != 2'b00)) begin
            alignErr_o = 1'b1;
        end
    end

    // Word loads ignore the sign-extend bit since nothing is left to extend
    always_comb begin
        loadData_o = shifted;
        case (size)
            SIZE_B:  loadData_o = {{24{signExt & shifted[7]}}, shifted[7:0]};
            SIZE_H:  loadData_o = {{16{signExt & shifted[15]}}, shifted[15:0]};
            default: loadData_o = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_23060201_dmem_rsp.sv
// ---------------------------------------------------------------------------
// ysyx_23060201_dmem_rsp
// Memory-side end of the EXU load/store port. Accepts one load or store per
// valid/ready handshake, waits LATENCY cycles, performs the SRAM access in
// the last WAIT cycle and holds the response until it is consumed.
// Ports:
//   clk, rst_n      clock (rising edge), async active-low reset
//   req_valid_i     request valid            req_ready_o  request accepted
//   req_wen_i       store request            req_ren_i    load request
//   req_addr_i      byte address             req_mask_i   [3:0] size, [4] sign-extend
//   req_wdata_i     store data, LSB-aligned
//   rsp_valid_o     response valid           rsp_ready_i  response consumed
//   rsp_rdata_o     load data (0 for stores/errors)
//   rsp_err_o       request rejected, no memory side effect
// ---------------------------------------------------------------------------
module ysyx_23060201_dmem_rsp
    import ysyx_23060201_dmem_pkg::*;
#(
    parameter int                        MEM_ADDR_WIDTH = 32,
    parameter int                        DATA_WIDTH     = 32,
    parameter int                        DEPTH_LOG2     = 12,
    parameter logic [MEM_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h8000_0000,
    parameter int                        LATENCY        = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_wen_i,
    input  logic                      req_ren_i,
    input  logic [MEM_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [7:0]                req_mask_i,
    input  logic [DATA_WIDTH-1:0]     req_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
    output logic                      rsp_err_o
);

    dmemState_e                state_q, state_d;
    logic [3:0]                waitCnt_q, waitCnt_d;
    logic                      reqWen_q, reqWen_d;
    logic                      reqRen_q, reqRen_d;
    logic [MEM_ADDR_WIDTH-1:0] reqAddr_q, reqAddr_d;
    logic [4:0]                reqMask_q, reqMask_d;
    logic [DATA_WIDTH-1:0]     reqWdata_q, reqWdata_d;
    logic [DATA_WIDTH-1:0]     rspRdata_q, rspRdata_d;
    logic                      rspErr_q, rspErr_d;

    logic [DATA_WIDTH-1:0]     mem [0:(2**DEPTH_LOG2)-1];

    logic [MEM_ADDR_WIDTH-1:0] addrOff;
    logic [DEPTH_LOG2-1:0]     wordIdx;
    logic                      outOfRange;
    logic                      alignErr;
    logic                      reqErr;
    logic                      doAccess;
    logic                      memWrite;
    logic [3:0]                strobe;
    logic [DATA_WIDTH-1:0]     laneData;
    logic [DATA_WIDTH-1:0]     loadData;
    logic                      unusedMaskBits;

    assign unusedMaskBits = ^req_mask_i[7:5];

    // Addresses below BASE_ADDR wrap to a huge offset and land out of range
    assign addrOff    = reqAddr_q - BASE_ADDR;
    assign wordIdx    = addrOff[DEPTH_LOG2+1:2];
    assign outOfRange = |addrOff[MEM_ADDR_WIDTH-1:DEPTH_LOG2+2];

    ysyx_23060201_dmem_align uAlign (
        .addrLo_i   (addrOff[1:0]),
        .mask_i     (reqMask_q),
        .wdata_i    (reqWdata_q),
        .rawWord_i  (mem[wordIdx]),
        .strobe_o   (strobe),
        .laneData_o (laneData),
        .alignErr_o (alignErr),
        .loadData_o (loadData)
    );

    assign reqErr   = (reqWen_q == reqRen_q) || alignErr || outOfRange;
    assign doAccess = (state_q == ST_WAIT) && (waitCnt_q == 4'd0);
    assign memWrite = doAccess && reqWen_q && !reqErr;

    // State, request latches and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            waitCnt_q  <= 4'd0;
            reqWen_q   <= 1'b0;
            reqRen_q   <= 1'b0;
            reqAddr_q  <= '0;
            reqMask_q  <= '0;
            reqWdata_q <= '0;
            rspRdata_q <= '0;
            rspErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            reqWen_q   <= reqWen_d;
            reqRen_q   <= reqRen_d;
            reqAddr_q  <= reqAddr_d;
            reqMask_q  <= reqMask_d;
            reqWdata_q <= reqWdata_d;
            rspRdata_q <= rspRdata_d;
            rspErr_q   <= rspErr_d;
        end
    end

    // Next-state logic; the access result is captured as WAIT exits
    always_comb begin
        state_d     = state_q;
        waitCnt_d   = waitCnt_q;
        reqWen_d    = reqWen_q;
        reqRen_d    = reqRen_q;
        reqAddr_d   = reqAddr_q;
        reqMask_d   = reqMask_q;
        reqWdata_d  = reqWdata_q;
        rspRdata_d  = rspRdata_q;
        rspErr_d    = rspErr_q;
        req_ready_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    reqWen_d   = req_wen_i;
                    reqRen_d   = req_ren_i;
                    reqAddr_d  = req_addr_i;
                    reqMask_d  = req_mask_i[4:0];
                    reqWdata_d = req_wdata_i;
                    waitCnt_d  = 4'(LATENCY);
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (waitCnt_q == 4'd0) begin
                    rspErr_d   = reqErr;
                    rspRdata_d = (reqErr || reqWen_q) ? '0 : loadData;
                    state_d    = ST_RESP;
                end else begin
                    waitCnt_d = waitCnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // SRAM is never reset; a store dropped by reset simply never reaches memWrite
    always_ff @(posedge clk) begin
        if (memWrite) begin
            for (int b = 0; b < 4; b++) begin
                if (strobe[b]) begin
                    mem[wordIdx][8*b +: 8] <= laneData[8*b +: 8];
                end
            end
        end
    end

    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_rdata_o = rspRdata_q;
    assign rsp_err_o   = rspErr_q;

endmodule

// File: tb/tb_ysyx_23060201_dmem_rsp.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060201_dmem_rsp
// Bench for the data-memory responder: vector table, reset and backpressure
// sequences, then random traffic against a byte-addressed memory model.
// ---------------------------------------------------------------------------
module tb_ysyx_23060201_dmem_rsp;

    localparam int          LAT        = 2;
    localparam int          DEPTH_LOG2 = 12;
    localparam logic [31:0] BASE       = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        reqValid;
    logic        reqReady;
    logic        reqWen;
    logic        reqRen;
    logic [31:0] reqAddr;
    logic [7:0]  reqMask;
    logic [31:0] reqWdata;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspRdata;
    logic        rspErr;

    int errors = 0;
    int checks = 0;

    logic [7:0] refBytes [int unsigned];

    typedef struct {
        string       name;
        logic        wen;
        logic        ren;
        logic [31:0] addr;
        logic [7:0]  mask;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expErr;
    } txnVec_t;

    txnVec_t vecs[$];

    ysyx_23060201_dmem_rsp #(
        .MEM_ADDR_WIDTH (32),
        .DATA_WIDTH     (32),
        .DEPTH_LOG2     (DEPTH_LOG2),
        .BASE_ADDR      (BASE),
        .LATENCY        (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (reqValid),
        .req_ready_o (reqReady),
        .req_wen_i   (reqWen),
        .req_ren_i   (reqRen),
        .req_addr_i  (reqAddr),
        .req_mask_i  (reqMask),
        .req_wdata_i (reqWdata),
        .rsp_valid_o (rspValid),
        .rsp_ready_i (rspReady),
        .rsp_rdata_o (rspRdata),
        .rsp_err_o   (rspErr)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural memory: byte-addressed, size from mask, sign extension by arithmetic
    task automatic refAccess(input logic wen, input logic ren, input logic [31:0] addr,
                             input logic [7:0] mask, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic err, output bit known);
        int          nBytes;
        logic [31:0] off;
        longint      val;
        case (mask[3:0])
            4'h1:    nBytes = 1;
            4'h3:    nBytes = 2;
            4'hF:    nBytes = 4;
            default: nBytes = 0;
        endcase
        off   = addr - BASE;
        rdata = 32'd0;
        known = 1'b1;
        err   = (wen == ren) || (nBytes == 0);
        if (!err && ((addr % nBytes) != 0)) err = 1'b1;
        if ((off / 4) >= (32'd1 << DEPTH_LOG2)) err = 1'b1;
        if (!err) begin
            if (wen) begin
                for (int i = 0; i < nBytes; i++) refBytes[addr + i] = wdata[8*i +: 8];
            end else begin
                val = 0;
                for (int i = 0; i < nBytes; i++) begin
                    if (refBytes.exists(addr + i)) val += longint'(refBytes[addr + i]) << (8 * i);
                    else known = 1'b0;
                end
                if (mask[4] && (nBytes < 4) && (val >= (longint'(1) << (8 * nBytes - 1))))
                    val -= (longint'(1) << (8 * nBytes));
                rdata = val[31:0];
            end
        end
    endtask

    // One full transaction with rsp_ready high: accept, latency count, response, release
    task automatic applyStimulus(input string name, input logic wen, input logic ren,
                                 input logic [31:0] addr, input logic [7:0] mask,
                                 input logic [31:0] wdata, output logic [31:0] rdata,
                                 output logic err, output bit got);
        int cyc;
        @(negedge clk);
        checkOutput({name, " req_ready"}, {31'd0, reqReady}, 32'd1);
        reqValid = 1'b1;
        reqWen   = wen;
        reqRen   = ren;
        reqAddr  = addr;
        reqMask  = mask;
        reqWdata = wdata;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        reqWen   = 1'($urandom);
        reqRen   = 1'($urandom);
        reqAddr  = $urandom;
        reqMask  = 8'($urandom);
        reqWdata = $urandom;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            if (rspValid) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        checkOutput({name, " latency"}, cyc, LAT + 1);
        rdata = rspRdata;
        err   = rspErr;
        if (got) begin
            @(posedge clk);
            #1;
            checkOutput({name, " rsp_valid drop"}, {31'd0, rspValid}, 32'd0);
        end
    endtask

    function automatic void addVec(string name, logic wen, logic ren, logic [31:0] addr,
                                   logic [7:0] mask, logic [31:0] wdata,
                                   logic [31:0] expRdata, logic expErr);
        txnVec_t v;
        v.name = name; v.wen = wen; v.ren = ren; v.addr = addr; v.mask = mask;
        v.wdata = wdata; v.expRdata = expRdata; v.expErr = expErr;
        vecs.push_back(v);
    endfunction

    // Test sequence: reset, reset-abort, table, backpressure, random
    initial begin
        logic [31:0] rd, mRd;
        logic        er, mErr;
        bit          got, known;
        int          cyc;

        addVec("stW 10",      1, 0, 32'h8000_0010, 8'h0F, 32'h1122_3344, 32'h0,         0);
        addVec("ldW 10",      0, 1, 32'h8000_0010, 8'h0F, 32'h0,         32'h1122_3344, 0);
        addVec("stB 13",      1, 0, 32'h8000_0013, 8'h01, 32'h0000_00AB, 32'h0,         0);
        addVec("ldB s 13",    0, 1, 32'h8000_0013, 8'h11, 32'h0,         32'hFFFF_FFAB, 0);
        addVec("ldB u 13",    0, 1, 32'h8000_0013, 8'h01, 32'h0,         32'h0000_00AB, 0);
        addVec("ldW 10 b",    0, 1, 32'h8000_0010, 8'h0F, 32'h0,         32'hAB22_3344, 0);
        addVec("ldH s 12",    0, 1, 32'h8000_0012, 8'h13, 32'h0,         32'hFFFF_AB22, 0);
        addVec("ldH 11 mis",  0, 1, 32'h8000_0011, 8'h03, 32'h0,         32'h0,         1);
        addVec("stW under",   1, 0, 32'h7FFF_FFFC, 8'h0F, 32'h5555_5555, 32'h0,         1);
        addVec("stW over",    1, 0, 32'h8000_4000, 8'h0F, 32'h5555_5555, 32'h0,         1);
        addVec("wen ren",     1, 1, 32'h8000_0010, 8'h0F, 32'h5555_5555, 32'h0,         1);
        addVec("no cmd",      0, 0, 32'h8000_0010, 8'h0F, 32'h5555_5555, 32'h0,         1);
        addVec("bad size",    0, 1, 32'h8000_0010, 8'h07, 32'h0,         32'h0,         1);
        addVec("ldW 12 mis",  0, 1, 32'h8000_0012, 8'h0F, 32'h0,         32'h0,         1);
        addVec("ldW 10 c",    0, 1, 32'h8000_0010, 8'h0F, 32'h0,         32'hAB22_3344, 0);
        addVec("stW 14",      1, 0, 32'h8000_0014, 8'h0F, 32'h0102_0304, 32'h0,         0);
        addVec("stH 16",      1, 0, 32'h8000_0016, 8'h03, 32'h1234_BEEF, 32'h0,         0);
        addVec("ldW 14",      0, 1, 32'h8000_0014, 8'h0F, 32'h0,         32'hBEEF_0304, 0);
        addVec("ldH u 16",    0, 1, 32'h8000_0016, 8'h03, 32'h0,         32'h0000_BEEF, 0);
        addVec("ldH s 16",    0, 1, 32'h8000_0016, 8'h13, 32'h0,         32'hFFFF_BEEF, 0);
        addVec("stW last",    1, 0, 32'h8000_3FFC, 8'h0F, 32'hCAFE_F00D, 32'h0,         0);
        addVec("ldW last",    0, 1, 32'h8000_3FFC, 8'hFF, 32'h0,         32'hCAFE_F00D, 0);

        rst_n    = 1'b0;
        reqValid = 1'b0;
        reqWen   = 1'b0;
        reqRen   = 1'b0;
        reqAddr  = 32'd0;
        reqMask  = 8'd0;
        reqWdata = 32'd0;
        rspReady = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset req_ready", {31'd0, reqReady}, 32'd1);
        checkOutput("reset rsp_valid", {31'd0, rspValid}, 32'd0);
        checkOutput("reset rsp_rdata", rspRdata, 32'd0);
        checkOutput("reset rsp_err", {31'd0, rspErr}, 32'd0);
        rst_n = 1'b1;

        // Reset in the middle of a store's WAIT must drop the store
        applyStimulus("init 00", 1, 0, BASE, 8'h0F, 32'h1111_1111, rd, er, got);
        refAccess(1, 0, BASE, 8'h0F, 32'h1111_1111, mRd, mErr, known);
        applyStimulus("ldW 00", 0, 1, BASE, 8'h0F, 32'h0, rd, er, got);
        checkOutput("ldW 00 rdata", rd, 32'h1111_1111);
        @(negedge clk);
        reqValid = 1'b1; reqWen = 1'b1; reqRen = 1'b0;
        reqAddr = BASE; reqMask = 8'h0F; reqWdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort req_ready", {31'd0, reqReady}, 32'd1);
        checkOutput("abort rsp_valid", {31'd0, rspValid}, 32'd0);
        checkOutput("abort rsp_rdata", rspRdata, 32'd0);
        checkOutput("abort rsp_err", {31'd0, rspErr}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("ldW 00 post", 0, 1, BASE, 8'h0F, 32'h0, rd, er, got);
        checkOutput("ldW 00 post rdata", rd, 32'h1111_1111);

        // Directed vector table
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].name, vecs[i].wen, vecs[i].ren, vecs[i].addr,
                          vecs[i].mask, vecs[i].wdata, rd, er, got);
            refAccess(vecs[i].wen, vecs[i].ren, vecs[i].addr, vecs[i].mask,
                      vecs[i].wdata, mRd, mErr, known);
            if (got) begin
                checkOutput({vecs[i].name, " rdata"}, rd, vecs[i].expRdata);
                checkOutput({vecs[i].name, " err"}, {31'd0, er}, {31'd0, vecs[i].expErr});
            end
        end

        // Backpressure: response held while rsp_ready is low, requests ignored
        refAccess(0, 1, 32'h8000_0010, 8'h0F, 32'h0, mRd, mErr, known);
        @(negedge clk);
        rspReady = 1'b0;
        reqValid = 1'b1; reqWen = 1'b0; reqRen = 1'b1;
        reqAddr = 32'h8000_0010; reqMask = 8'h0F; reqWdata = 32'h0;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        cyc = 0;
        while (!rspValid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("bp latency", cyc, LAT + 1);
        reqValid = 1'b1; reqWen = 1'b1; reqRen = 1'b0;
        reqAddr = 32'h8000_0010; reqMask = 8'h0F; reqWdata = 32'h5A5A_5A5A;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checkOutput("bp rsp_valid", {31'd0, rspValid}, 32'd1);
            checkOutput("bp rsp_rdata", rspRdata, mRd);
            checkOutput("bp rsp_err", {31'd0, rspErr}, 32'd0);
            checkOutput("bp req_ready", {31'd0, reqReady}, 32'd0);
        end
        rspReady = 1'b1;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        checkOutput("bp release rsp_valid", {31'd0, rspValid}, 32'd0);
        checkOutput("bp release req_ready", {31'd0, reqReady}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("bp idle req_ready", {31'd0, reqReady}, 32'd1);
        applyStimulus("bp ldW 10", 0, 1, 32'h8000_0010, 8'h0F, 32'h0, rd, er, got);
        checkOutput("bp ldW 10 rdata", rd, mRd);

        // Seed a small region with full words, then random traffic
        for (int w = 0; w < 16; w++) begin
            logic [31:0] a, d;
            a = 32'h8000_0100 + 32'(4 * w);
            d = $urandom;
            applyStimulus("seed", 1, 0, a, 8'h0F, d, rd, er, got);
            refAccess(1, 0, a, 8'h0F, d, mRd, mErr, known);
        end
        for (int n = 0; n < 150; n++) begin
            logic        w, r;
            logic [31:0] a, d;
            logic [7:0]  m;
            int          kind;
            kind = int'($urandom_range(0, 9));
            w = 1'($urandom);
            r = ~w;
            if (kind == 0) r = w;
            case ($urandom_range(0, 6))
                0, 1:    m = 8'h01;
                2, 3:    m = 8'h03;
                4, 5:    m = 8'h0F;
                default: m = 8'($urandom_range(0, 15));
            endcase
            m[4]   = 1'($urandom);
            m[7:5] = 3'($urandom);
            a = 32'h8000_0100 + 32'($urandom_range(0, 63));
            if (kind == 1) a = $urandom;
            d = $urandom;
            applyStimulus("rand", w, r, a, m, d, rd, er, got);
            refAccess(w, r, a, m, d, mRd, mErr, known);
            if (got) begin
                checkOutput("rand err", {31'd0, er}, {31'd0, mErr});
                if (known) checkOutput("rand rdata", rd, mRd);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
